step_seq: RTL and testbench
===========================

// Module: step_seq
// PURPOSE
//   Instruction step sequencer for the 8-bit core. Drives the one-cycle active-low enable
//   pulses of the fetch, decode and execute step blocks in order: IF -> ID -> EX[sel] -> IF.
//   Each step signals completion on the shared wired active-low rdy_ line, which is pulled up.
//   Also owns halt handling, a per-step watchdog and a retired-instruction counter.
// PARAMETERS
//   NUM_EX   4   number of execute step blocks (ld, st, alu, jmp); legal range 1..4
//   TIMEOUT  15  max WAIT-state samples without rdy_ before fault; legal range 1..255
// PORTS
//   clk       in   1        system clock; all state changes on posedge
//   rst_      in   1        asynchronous active-low reset
//   rdy_      in   1        shared step-complete line; 0 = done; pulled-up Z reads as 1
//   halt_     in   1        active-low halt request; takes effect at the instruction boundary
//   ex_sel    in   2        execute-unit index; sampled on the edge where decode rdy_ is seen
//   ena_if_   out  1        fetch-step enable, active-low one-cycle pulse
//   ena_id_   out  1        decode-step enable, active-low one-cycle pulse
//   ena_ex_   out  NUM_EX   per-unit execute enables, active-low, at most one bit low at a time
//   running   out  1        1 while in any FETCH/DEC/EX state
//   fault     out  1        sticky watchdog / bad-select error flag
//   icnt      out  8        count of retired instructions, wraps
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, all ena_* = 1, running=0, fault=0, icnt=0,
//     latched sel=0, wdog=0. All outputs are registered.
//   States: IDLE, IF_W, ID_W, EX_W, FAULT. An enable pulse is registered on the edge that
//     enters a *_W state, so the pulse is low for exactly the first cycle of that state.
//   IDLE: if halt_=1 then ena_if_<=0 and go to IF_W; else stay. rdy_ is ignored in IDLE.
//   IF_W: when rdy_=0 is sampled, ena_id_<=0 and go to ID_W.
//   ID_W: when rdy_=0 is sampled, latch ex_sel.
//     If ex_sel>=NUM_EX: go to FAULT.
//     Else ena_ex_[ex_sel]<=0 and go to EX_W.
//   EX_W: when rdy_=0 is sampled, icnt<=icnt+1 (mod 256).
//     If halt_=0: go to IDLE.
//     Else ena_if_<=0 and go to IF_W (back-to-back, no idle cycle).
//   rdy_ sampled on the same edge that ends a pulse is acted on. Units never reply that fast,
//     and the sequencer applies no masking.
//   Latency: for a unit that raises rdy_ low N cycles after seeing ena_, the next ena_
//     falls N+1 cycles after the previous one.
//   Watchdog: wdog clears on entry to any *_W state and increments on each WAIT sample
//     with rdy_=1. When wdog reaches TIMEOUT: go to FAULT.
//   FAULT: fault=1, all ena_*=1, running=0. Exit only via rst_.
//   halt_ is a level, never latched. Asserting it mid-instruction has no effect until the
//     EX rdy_ is sampled.
//   Simultaneous rdy_=0 and wdog==TIMEOUT-1 on the same edge: rdy_ wins (step completes).
//   Reset mid-step: the step block's own rdy_ may still pulse afterwards. IDLE ignores it.
// TESTING
//   1 Reset release, halt_=1, NUM_EX=4, each unit answers rdy_ 3 cycles after ena_, ex_sel=1.
//     -> ena_if_ low c1, ena_id_ low c5, ena_ex_[1] low c9, icnt=1 and ena_if_ low c13.
//   2 halt_=0 driven during EX_W of instr 1.
//     -> after EX rdy_: IDLE, running=0, icnt=1, no ena_ for 20 cycles.
//     -> release halt_ -> ena_if_ low on the next cycle.
//   3 ena_id_ issued, rdy_ held high (TIMEOUT=15).
//     -> fault=1 after 15 WAIT samples, all ena_ high, persists 50 cycles until rst_.
//   4 NUM_EX=3, decode done with ex_sel=3.
//     -> FAULT next cycle, no ena_ex_ bit ever low, fault=1.
//   5 rst_ asserted mid EX_W (async, between edges).
//     -> ena_*=1, icnt=0, fault=0 immediately; a late rdy_ pulse is ignored.
//     -> after release, normal fetch.
//   6 Run 256 instructions back-to-back.
//     -> icnt wraps 255->0, no idle cycle between EX rdy_ and the next ena_if_.

Source files
------------

// File: rtl/step_seq.sv
// ----------------------------------------------------------------------------
// step_seq -- instruction step sequencer for the 8-bit core.
//
// Walks the fetch, decode and execute step blocks in order
// (IF -> ID -> EX[sel] -> IF), issuing a one-cycle active-low enable pulse to
// each block and waiting for it to complete on the shared, pulled-up, wired
// active-low rdy_ line. Also handles halt at the instruction boundary, runs a
// per-step watchdog and counts retired instructions.
//
// Parameters
//   NUM_EX   number of execute step blocks (1..4)
//   TIMEOUT  WAIT-state samples without rdy_ before a fault (1..255)
//
// Ports
//   clk       in   system clock, all state changes on posedge
//   rst_      in   asynchronous active-low reset
//   rdy_      in   shared step-complete line, 0 = done
//   halt_     in   active-low halt request, honoured at the instruction boundary
//   ex_sel    in   execute-unit index, sampled when decode completes
//   ena_if_   out  fetch-step enable pulse (active low)
//   ena_id_   out  decode-step enable pulse (active low)
//   ena_ex_   out  per-unit execute enable pulses (active low, at most one low)
//   running   out  1 while fetching, decoding or executing
//   fault     out  sticky watchdog / bad-select error flag
//   icnt      out  retired-instruction count, wraps at 256
// ----------------------------------------------------------------------------
module step_seq #(
    parameter int unsigned NUM_EX  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              rdy_,
    input  logic              halt_,
    input  logic [1:0]        ex_sel,
    output logic              ena_if_,
    output logic              ena_id_,
    output logic [NUM_EX-1:0] ena_ex_,
    output logic              running,
    output logic              fault,
    output logic [7:0]        icnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_IF_W  = 3'd1;
    localparam logic [2:0] S_ID_W  = 3'd2;
    localparam logic [2:0] S_EX_W  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [2:0] NUM_EX_L  = 3'(NUM_EX);
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [7:0]        wdog;
    logic [7:0]        wdog_nxt;
    logic              go_if;
    logic              go_id;
    logic              go_ex;
    logic              retire;
    logic              ex_valid;
    logic [NUM_EX-1:0] ex_en_n;

    assign ex_valid = ({1'b0, ex_sel} < NUM_EX_L);

    // Active-low one-hot decode of the requested execute unit. The selected
    // unit is captured straight into ena_ex_ on the decode-ready edge.
    always_comb begin
        ex_en_n = '1;
        for (int unsigned i = 0; i < NUM_EX; i++) begin
            if (ex_sel == 2'(i)) begin
                ex_en_n[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wdog_nxt  = wdog;
        go_if     = 1'b0;
        go_id     = 1'b0;
        go_ex     = 1'b0;
        retire    = 1'b0;

        case (state)
            S_IDLE: begin
                if (halt_) begin
                    go_if     = 1'b1;
                    state_nxt = S_IF_W;
                end
            end

            S_IF_W, S_ID_W, S_EX_W: begin
                // A completing step takes priority over a watchdog expiry
                // landing on the same edge.
                if (!rdy_) begin
                    if (state == S_IF_W) begin
                        go_id     = 1'b1;
                        state_nxt = S_ID_W;
                    end else if (state == S_ID_W) begin
                        if (ex_valid) begin
                            go_ex     = 1'b1;
                            state_nxt = S_EX_W;
                        end else begin
                            state_nxt = S_FAULT;
                        end
                    end else begin
                        retire = 1'b1;
                        if (halt_) begin
                            go_if     = 1'b1;
                            state_nxt = S_IF_W;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end else if (wdog == WDOG_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    wdog_nxt = wdog + 8'd1;
                end
            end

            S_FAULT: begin
                state_nxt = S_FAULT;
            end

            default: begin
                state_nxt = S_FAULT;
            end
        endcase

        if (go_if || go_id || go_ex) begin
            wdog_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= S_IDLE;
            wdog    <= '0;
            ena_if_ <= 1'b1;
            ena_id_ <= 1'b1;
            ena_ex_ <= '1;
            running <= 1'b0;
            fault   <= 1'b0;
            icnt    <= '0;
        end else begin
            state   <= state_nxt;
            wdog    <= wdog_nxt;
            // Enables are low only for the first cycle of the entered state.
            ena_if_ <= !go_if;
            ena_id_ <= !go_id;
            ena_ex_ <= go_ex ? ex_en_n : '1;
            running <= (state_nxt inside {S_IF_W, S_ID_W, S_EX_W});
            fault   <= fault || (state_nxt == S_FAULT);
            if (retire) begin
                icnt <= icnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_step_seq.sv
`timescale 1ns/1ps
module tb_step_seq;

    localparam int NX = 4;

    logic          clk = 1'b0;
    logic          rst_;
    logic          rdy_;
    logic          halt_;
    logic [1:0]    ex_sel;
    logic          ena_if_;
    logic          ena_id_;
    logic [NX-1:0] ena_ex_;
    logic          running;
    logic          fault;
    logic [7:0]    icnt;

    // Second instance with three execute units for the bad-select case.
    logic          rdy3_;
    logic          halt3_;
    logic [1:0]    sel3;
    logic          ena_if3_;
    logic          ena_id3_;
    logic [2:0]    ena_ex3_;
    logic          running3;
    logic          fault3;
    logic [7:0]    icnt3;

    always #5 clk = ~clk;

    step_seq #(.NUM_EX(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_(rst_), .rdy_(rdy_), .halt_(halt_), .ex_sel(ex_sel),
        .ena_if_(ena_if_), .ena_id_(ena_id_), .ena_ex_(ena_ex_),
        .running(running), .fault(fault), .icnt(icnt)
    );

    step_seq #(.NUM_EX(3), .TIMEOUT(15)) dut3 (
        .clk(clk), .rst_(rst_), .rdy_(rdy3_), .halt_(halt3_), .ex_sel(sel3),
        .ena_if_(ena_if3_), .ena_id_(ena_id3_), .ena_ex_(ena_ex3_),
        .running(running3), .fault(fault3), .icnt(icnt3)
    );

    typedef struct { int kind; int cyc; } ev_t;   // kind: 0=IF 1=ID 2+i=EX[i]
    typedef struct { int delay; logic [1:0] sel; int exp_len; } vec_t;

    ev_t        exp_q[$];
    ev_t        ev;
    vec_t       tbl[6];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;

    bit         mon_en = 0;
    int         resp_delay = 3;
    bit         mute_id = 0;
    bit         armed = 0;
    int         cd = 0;
    int         stage = 0;
    bit         stage_mute = 0;
    bit         rdy_pulsed = 0;
    logic [7:0] exp_icnt = 8'd0;
    logic [7:0] prev_icnt = 8'd0;
    bit         saw_wrap = 0;
    int         if_cnt = 0, id_cnt = 0, ex_cnt = 0;
    int         last_if_cyc = 0, last_id_cyc = 0;
    int         lows, kind;
    bit         ex3_low_seen = 0;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int get_cnt(input int which);
        if (which == 0) return if_cnt;
        if (which == 1) return id_cnt;
        return ex_cnt;
    endfunction

    task automatic wait_kind(input int which, input string name);
        int s;
        bit got;
        s   = get_cnt(which);
        got = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (get_cnt(which) != s) begin
                got = 1;
                break;
            end
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_icnt   = 8'd0;
        prev_icnt  = 8'd0;
        armed      = 0;
        rdy_pulsed = 0;
        rdy_       = 1'b1;
    endtask

    // Scoreboard monitor and step-unit responder for the main instance.
    always @(negedge clk) begin
        if (rst_ && mon_en) begin
            if (rdy_pulsed) begin
                rdy_       = 1'b1;
                rdy_pulsed = 0;
            end
            check("icnt", 32'(icnt), 32'(exp_icnt));
            if (prev_icnt == 8'hFF && icnt == 8'h00) saw_wrap = 1;
            prev_icnt = icnt;

            lows = 0;
            kind = -1;
            if (!ena_if_) begin lows++; kind = 0; end
            if (!ena_id_) begin lows++; kind = 1; end
            for (int i = 0; i < NX; i++) begin
                if (!ena_ex_[i]) begin lows++; kind = 2 + i; end
            end
            if (lows > 1) check("one_enable_low", 32'(lows), 32'd1);
            if (lows == 1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_queue", 32'(exp_q.size()), 32'd1);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", 32'(kind), 32'(ev.kind));
                    check("pulse_cycle", 32'(cyc), 32'(ev.cyc));
                end
                if (kind == 0) begin if_cnt++; last_if_cyc = cyc; end
                else if (kind == 1) begin id_cnt++; last_id_cyc = cyc; end
                else ex_cnt++;
                armed      = 1;
                cd         = resp_delay;
                stage      = kind;
                stage_mute = (kind == 1) && mute_id;
            end

            if (armed) begin
                if (cd == 0) begin
                    armed = 0;
                    if (!stage_mute) begin
                        rdy_       = 1'b0;
                        rdy_pulsed = 1;
                        if (stage == 0) exp_q.push_back(ev_t'{1, cyc + 1});
                        else if (stage == 1) exp_q.push_back(ev_t'{2 + int'(ex_sel), cyc + 1});
                        else begin
                            exp_icnt = exp_icnt + 8'd1;
                            if (halt_) exp_q.push_back(ev_t'{0, cyc + 1});
                        end
                    end
                end else begin
                    cd--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_ && ena_ex3_ != 3'b111) ex3_low_seen = 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t, ok, snap, start_icnt;

        // {reply delay, ex_sel, expected IF-to-IF period}
        tbl[0] = '{3,  2'd0, 12};
        tbl[1] = '{1,  2'd2, 6};
        tbl[2] = '{0,  2'd3, 3};
        tbl[3] = '{14, 2'd2, 45};   // reply lands with the watchdog on its last count
        tbl[4] = '{5,  2'd1, 18};
        tbl[5] = '{2,  2'd3, 9};

        rst_ = 1'b0; halt_ = 1'b1; rdy_ = 1'b1; ex_sel = 2'd1;
        halt3_ = 1'b0; rdy3_ = 1'b1; sel3 = 2'd0;
        repeat (3) tick();

        check("rst_ena_if", 32'(ena_if_), 32'd1);
        check("rst_ena_id", 32'(ena_id_), 32'd1);
        check("rst_ena_ex", 32'(ena_ex_), 32'hF);
        check("rst_running", 32'(running), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_icnt", 32'(icnt), 32'd0);

        // Case 1: first instruction timing from reset release.
        resp_delay = 3;
        exp_q.push_back(ev_t'{0, 1});
        mon_en = 1;
        @(negedge clk) rst_ = 1'b1;
        for (int k = 0; k < 30 && cyc < 13; k++) tick();
        check("c13_cycle", 32'(cyc), 32'd13);
        check("c13_icnt", 32'(icnt), 32'd1);
        check("c13_ena_if", 32'(ena_if_), 32'd0);
        check("c13_running", 32'(running), 32'd1);

        // Case 2: halt during EX_W of the second instruction (EX_W is c21..c24).
        for (int k = 0; k < 30 && cyc < 22; k++) tick();
        halt_ = 1'b0;
        check("halt_mid_running", 32'(running), 32'd1);
        for (int k = 0; k < 30 && cyc < 25; k++) tick();
        check("halt_idle_running", 32'(running), 32'd0);
        check("halt_idle_icnt", 32'(icnt), 32'd2);
        snap = if_cnt + id_cnt + ex_cnt;
        repeat (20) tick();
        check("halt_no_pulses", 32'(if_cnt + id_cnt + ex_cnt), 32'(snap));
        check("halt_still_idle", 32'(running), 32'd0);
        halt_ = 1'b1;
        exp_q.push_back(ev_t'{0, cyc + 1});
        tick();
        check("unhalt_ena_if", 32'(ena_if_), 32'd0);

        // Table-driven instruction periods.
        for (int r = 0; r < 6; r++) begin
            resp_delay = tbl[r].delay;
            ex_sel     = tbl[r].sel;
            wait_kind(0, "tbl_wait_a");
            wait_kind(0, "tbl_wait_b");
            t0 = last_if_cyc;
            wait_kind(0, "tbl_wait_c");
            check($sformatf("instr_len_%0d", r), 32'(last_if_cyc - t0), 32'(tbl[r].exp_len));
        end
        check("no_fault_after_table", 32'(fault), 32'd0);

        // Case 6: 256 back-to-back instructions, icnt wraps.
        resp_delay = 0;
        ex_sel     = 2'd3;
        wait_kind(0, "b2b_settle");
        start_icnt = int'(icnt);
        saw_wrap   = 0;
        for (int k = 0; k < 256; k++) wait_kind(0, "b2b_if");
        check("b2b_icnt_wrapped", 32'(icnt), 32'(start_icnt));
        check("b2b_saw_wrap", 32'(saw_wrap), 32'd1);
        resp_delay = 3;

        // Case 3: decode never answers, watchdog faults.
        ex_sel  = 2'd0;
        mute_id = 1;
        wait_kind(1, "wd_wait_id");
        mute_id = 0;
        t = last_id_cyc;
        for (int k = 0; k < 100 && cyc < t + 14; k++) @(negedge clk);
        check("wd_not_yet", 32'(fault), 32'd0);
        @(negedge clk);
        check("wd_fault", 32'(fault), 32'd1);
        check("wd_running", 32'(running), 32'd0);
        check("wd_enables", 32'({ena_if_, ena_id_, ena_ex_}), 32'h3F);
        ok = 0;
        repeat (50) begin
            @(negedge clk);
            if (fault && !running && ena_if_ && ena_id_ && ena_ex_ == 4'hF) ok++;
        end
        check("wd_fault_hold", 32'(ok), 32'd50);
        tick();
        mon_en = 0;
        rst_   = 1'b0;
        #1;
        check("wd_rst_fault", 32'(fault), 32'd0);
        clear_model();
        halt_ = 1'b1;
        exp_q.push_back(ev_t'{0, 1});
        mon_en = 1;
        @(negedge clk) rst_ = 1'b1;

        // Case 5: asynchronous reset mid EX_W, late rdy_ ignored.
        ex_sel = 2'd2;
        wait_kind(2, "ar_wait_ex");
        mon_en = 0;
        halt_  = 1'b0;
        #3 rst_ = 1'b0;
        #1;
        check("ar_enables", 32'({ena_if_, ena_id_, ena_ex_}), 32'h3F);
        check("ar_icnt", 32'(icnt), 32'd0);
        check("ar_fault", 32'(fault), 32'd0);
        check("ar_running", 32'(running), 32'd0);
        clear_model();
        @(negedge clk) rst_ = 1'b1;
        @(negedge clk) rdy_ = 1'b0;
        @(negedge clk) rdy_ = 1'b1;
        tick();
        check("ar_late_rdy_running", 32'(running), 32'd0);
        check("ar_late_rdy_enables", 32'({ena_if_, ena_id_, ena_ex_}), 32'h3F);
        check("ar_late_rdy_icnt", 32'(icnt), 32'd0);
        mon_en = 1;
        halt_  = 1'b1;
        exp_q.push_back(ev_t'{0, cyc + 1});
        tick();
        check("ar_fetch", 32'(ena_if_), 32'd0);
        wait_kind(0, "ar_next_fetch");

        // Drain the main instance to idle.
        halt_ = 1'b0;
        repeat (60) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("drained_idle", 32'(running), 32'd0);

        // Case 4: three-unit instance, decode returns ex_sel=3.
        check("bs_fault_before", 32'(fault3), 32'd0);
        @(negedge clk) halt3_ = 1'b1;
        @(negedge clk);
        check("bs_ena_if", 32'(ena_if3_), 32'd0);
        rdy3_  = 1'b0;
        halt3_ = 1'b0;
        @(negedge clk);
        check("bs_ena_id", 32'(ena_id3_), 32'd0);
        sel3 = 2'd3;
        @(negedge clk);
        rdy3_ = 1'b1;
        check("bs_fault", 32'(fault3), 32'd1);
        check("bs_running", 32'(running3), 32'd0);
        check("bs_enables", 32'({ena_if3_, ena_id3_, ena_ex3_}), 32'h1F);
        repeat (10) @(negedge clk);
        check("bs_fault_sticky", 32'(fault3), 32'd1);
        check("bs_no_ex_pulse", 32'(ex3_low_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
